// File: rtl/id_rf_bypass.sv
// id_rf_bypass: 32x32 GPR file with EX/MEM/WB bypass and load-use interlock.
// Define RF_PERF_EN to add the perf_stall_cnt stall-cycle counter port.
module id_rf_bypass #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [37:0]       ws_rf_bus,
  input  logic [38:0]       es_fwd_bus,
  input  logic [37:0]       ms_fwd_bus,
  input  logic [37:0]       ws_fwd_bus,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic              ds_valid,
  output logic [31:0]       rdata1,
  output logic [31:0]       rdata2,
`ifdef RF_PERF_EN
  output logic              ds_stall,
  output logic [PERF_W-1:0] perf_stall_cnt
`else
  output logic              ds_stall
`endif
);

  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  assign {wb_we, wb_waddr, wb_wdata} = ws_rf_bus;

  logic        es_we;
  logic [4:0]  es_dest;
  logic [31:0] es_res;
  logic        es_load;
  assign {es_we, es_dest, es_res, es_load} = es_fwd_bus;

  logic        ms_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_res;
  assign {ms_we, ms_dest, ms_res} = ms_fwd_bus;

  logic        wf_we;
  logic [4:0]  wf_dest;
  logic [31:0] wf_res;
  assign {wf_we, wf_dest, wf_res} = ws_fwd_bus;

  logic [31:0] rf [32];

  logic [4:0]  ra [2];
  logic [31:0] rd [2];
  logic        hx [2];
  logic        hm [2];
  logic        hw [2];

  assign ra[0]  = raddr1;
  assign ra[1]  = raddr2;
  assign rdata1 = rd[0];
  assign rdata2 = rd[1];

  if (PERF_W < 1) begin : g_bad_w
    $error("PERF_W must be at least 1");
  end

  // commit writeback writes; r0 is never written so it stays 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_we && wb_waddr != 5'd0) begin
      rf[wb_waddr] <= wb_wdata;
    end
  end

  // per-port bypass select, youngest producer first
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hx[p] = (ra[p] != 5'd0) && es_we
            && (es_dest == ra[p]);
      hm[p] = (ra[p] != 5'd0) && ms_we
            && (ms_dest == ra[p]) && !hx[p];
      hw[p] = (ra[p] != 5'd0) && wf_we
            && (wf_dest == ra[p])
            && !hx[p] && !hm[p];
      rd[p] = '0;
      unique case (1'b1)
        (ra[p] == 5'd0): rd[p] = '0;
        hx[p]:           rd[p] = es_res;
        hm[p]:           rd[p] = ms_res;
        hw[p]:           rd[p] = wf_res;
        default:         rd[p] = rf[ra[p]];
      endcase
    end
  end

  assign ds_stall = ds_valid & es_we & es_load
                  & (es_dest != 5'd0)
                  & ((rs1_used & (es_dest == raddr1))
                   | (rs2_used & (es_dest == raddr2)));

`ifdef RF_PERF_EN
  // count cycles in which decode is interlocked
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
    end else if (ds_stall) begin
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_rf_bypass.sv
// tb_id_rf_bypass: scoreboard bench for id_rf_bypass.
// Directed cases then randomized traffic against a register-file model.
module tb_id_rf_bypass;

  logic        clk = 1'b0;
  logic        resetn;
  logic [37:0] ws_rf_bus;
  logic [38:0] es_fwd_bus;
  logic [37:0] ms_fwd_bus;
  logic [37:0] ws_fwd_bus;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        rs1_used;
  logic        rs2_used;
  logic        ds_valid;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        ds_stall;
`ifdef RF_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  id_rf_bypass #(.PERF_W(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_rf_bus      (ws_rf_bus),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus),
    .ws_fwd_bus     (ws_fwd_bus),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .rs1_used       (rs1_used),
    .rs2_used       (rs2_used),
    .ds_valid       (ds_valid),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
`ifdef RF_PERF_EN
    .ds_stall       (ds_stall),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .ds_stall       (ds_stall)
`endif
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mrf [32];
  int unsigned mcnt = 0;

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic        v [3];
    logic [4:0]  d [3];
    logic [31:0] x [3];
    if (a == 5'd0) return 32'd0;
    v = '{es_fwd_bus[38], ms_fwd_bus[37], ws_fwd_bus[37]};
    d = '{es_fwd_bus[37:33], ms_fwd_bus[36:32], ws_fwd_bus[36:32]};
    x = '{es_fwd_bus[32:1], ms_fwd_bus[31:0], ws_fwd_bus[31:0]};
    for (int s = 0; s < 3; s++) begin
      if (v[s] && d[s] == a) return x[s];
    end
    return mrf[a];
  endfunction

  function automatic logic mstall();
    logic [4:0] d;
    d = es_fwd_bus[37:33];
    return ds_valid && es_fwd_bus[38] && es_fwd_bus[0] && d != 5'd0
        && ((rs1_used && d == raddr1) || (rs2_used && d == raddr2));
  endfunction

  task automatic clr();
    ws_rf_bus  = '0;
    es_fwd_bus = '0;
    ms_fwd_bus = '0;
    ws_fwd_bus = '0;
    raddr1     = '0;
    raddr2     = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    ds_valid   = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mcnt = 0;
  endtask

  task automatic issue();
    exp_t e;
    if (!resetn) model_reset();
    e.r1  = mread(raddr1);
    e.r2  = mread(raddr2);
    e.st  = mstall();
    e.cnt = mcnt;
    q.push_back(e);
    if (resetn) begin
      if (ws_rf_bus[37] && ws_rf_bus[36:32] != 5'd0)
        mrf[ws_rf_bus[36:32]] = ws_rf_bus[31:0];
      if (e.st) mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // monitor: outputs are valid every cycle once an expectation is queued
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata1", rdata1, e.r1);
        chk("rdata2", rdata2, e.r2);
        chk("ds_stall", {31'd0, ds_stall}, {31'd0, e.st});
`ifdef RF_PERF_EN
        chk("perf_cnt", perf_stall_cnt, e.cnt);
`endif
      end
    end
  end

  initial begin
    clr();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    raddr1 = 5'd5;
    raddr2 = 5'd0;
    issue();
    resetn = 1'b1;

    ws_rf_bus  = {1'b1, 5'd3, 32'h12345678};
    ws_fwd_bus = {1'b1, 5'd3, 32'h12345678};
    raddr1 = 5'd3;
    issue();
    clr();
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    issue();

    ws_rf_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
    issue();
    clr();
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    issue();

    es_fwd_bus = {1'b1, 5'd7, 32'hA, 1'b0};
    ms_fwd_bus = {1'b1, 5'd7, 32'hB};
    ws_fwd_bus = {1'b1, 5'd7, 32'hC};
    raddr1 = 5'd7;
    raddr2 = 5'd7;
    issue();
    es_fwd_bus[38] = 1'b0;
    issue();
    ms_fwd_bus[37] = 1'b0;
    issue();

    clr();
    es_fwd_bus = {1'b1, 5'd9, 32'h99, 1'b1};
    raddr2   = 5'd9;
    rs2_used = 1'b1;
    ds_valid = 1'b1;
    issue();
    rs2_used = 1'b0;
    issue();
    rs2_used = 1'b1;
    ds_valid = 1'b0;
    issue();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 5'd9, 32'h55};
    ds_valid   = 1'b1;
    issue();

    clr();
    resetn = 1'b0;
    issue();
    resetn = 1'b1;
    ws_rf_bus = {1'b1, 5'd4, 32'hDEAD};
    issue();
    clr();
    es_fwd_bus = {1'b1, 5'd9, 32'h1, 1'b1};
    raddr1   = 5'd9;
    rs1_used = 1'b1;
    ds_valid = 1'b1;
    repeat (4) issue();
    ws_rf_bus = {1'b1, 5'd6, 32'hBEEF};
    raddr2 = 5'd4;
    resetn = 1'b0;
    issue();
    issue();
    resetn = 1'b1;
    clr();
    raddr1 = 5'd6;
    raddr2 = 5'd4;
    issue();

    for (int n = 0; n < 600; n++) begin
      ws_rf_bus  = {1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 7)), 32'($urandom)};
      es_fwd_bus = {1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)), 32'($urandom),
                    1'($urandom_range(0, 1))};
      ms_fwd_bus = {1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)), 32'($urandom)};
      ws_fwd_bus = {1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 7)), 32'($urandom)};
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      ds_valid = 1'($urandom_range(0, 3) != 0);
      resetn   = 1'($urandom_range(0, 63) != 0);
      issue();
    end
    resetn = 1'b1;

    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_rf_bypass.md
Name: id_rf_bypass

Overview:
- Decode-side consumer of the writeback register-write bus and the execute/memory/writeback forwarding buses.
- Holds the 32x32 general register file and commits writeback writes on the clock edge.
- Serves two combinational read ports with priority bypass: EX over MEM over WB over the array.
- Raises a load-use stall to the decode stage when a needed operand is a load result still in EX.

Parameters:
- PERF_W, 32, width of the optional stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ws_rf_bus  in  38  writeback commit: [37]=we (already qualified by WB valid), [36:32]=waddr, [31:0]=wdata.
- es_fwd_bus  in  39  EX forward: [38]=we&valid, [37:33]=dest, [32:1]=result, [0]=is_load.
- ms_fwd_bus  in  38  MEM forward: [37]=we&valid, [36:32]=dest, [31:0]=result (load data final).
- ws_fwd_bus  in  38  WB forward, same layout as ms_fwd_bus.
- raddr1  in  5  source register 1 index.
- raddr2  in  5  source register 2 index.
- rs1_used  in  1  decoded instruction reads raddr1.
- rs2_used  in  1  decoded instruction reads raddr2.
- ds_valid  in  1  decode stage holds a valid instruction.
- rdata1  out  32  bypassed operand 1.
- rdata2  out  32  bypassed operand 2.
- ds_stall  out  1  load-use interlock; decode must not issue.
- perf_stall_cnt  out  PERF_W  stall-cycle count (only with RF_PERF_EN).

Behaviour:
- Reset (resetn low, asynchronous): all 32 registers cleared to 0; perf counter cleared to 0. Outputs are combinational over state and inputs, so with no forwarding hits rdata1/rdata2 = 0 and ds_stall = 0.
- Commit: on posedge clk, if ws_rf_bus[37]=1 and waddr!=0, reg[waddr] <= wdata. Writes to r0 are discarded; r0 always reads 0.
- Read, per port, zero-latency combinational selection in this order:
  - raddr==0 -> 0, never forwarded.
  - EX hit (es we & dest==raddr) -> es result, even when is_load (value unused because ds_stall is set).
  - MEM hit -> ms result.
  - WB hit -> ws result. This covers same-cycle write+read of one register: a read returns the new data in the cycle the write is presented.
  - Otherwise -> reg[raddr].
- Stall: ds_stall = ds_valid & es_we & es_is_load & es_dest!=0 & ((rs1_used & es_dest==raddr1) | (rs2_used & es_dest==raddr2)).
  - The unused operand port never causes a stall.
  - MEM/WB load hits never stall: data is final there.
- Simultaneous hits from several stages on one register: the youngest stage (EX) wins.
- Both ports reading the same register: identical data.
- Reset asserted mid-operation: the array is cleared immediately; a WB write presented in the same cycle is lost.

Optional Feature:
- Macro RF_PERF_EN.
- Defined: perf_stall_cnt exists and increments by 1 on each posedge clk where ds_stall=1. It wraps from all-ones to 0, and resets to 0.
- Undefined: no perf_stall_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then read r5 and r0 -> rdata1=0, rdata2=0, ds_stall=0.
- WB write r3=0x12345678 (we=1) for one cycle, then read r3 with no forward hits -> 0x12345678. Read r3 in the same cycle as the write -> 0x12345678 via the WB bypass.
- WB write r0=0xFFFFFFFF, then read r0 -> 0.
- EX dest r7=0xA, MEM r7=0xB, WB r7=0xC all valid, read r7 on both ports -> 0xA on both. Drop the EX hit -> 0xB. Drop the MEM hit -> 0xC.
- EX load r9, raddr2=9: rs2_used=1, ds_valid=1 -> ds_stall=1; rs2_used=0 -> ds_stall=0; ds_valid=0 -> ds_stall=0. The same load in MEM -> ds_stall=0 and rdata2=MEM result.
- With RF_PERF_EN, hold ds_stall high for 3 cycles -> perf_stall_cnt=3. Assert resetn low asynchronously mid-stall -> counter=0 and all registers read 0 immediately.
